// File: rtl/counter_pkg.sv
// counter_pkg: shared width default and count direction type for the up/down counter.
package counter_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_e;
endpackage

// File: rtl/counter_run_flag.sv
// counter_run_flag: set/clear run flag, priority CLR > START > END > hold.
module counter_run_flag (
  input  logic CLK,
  input  logic RESETn,
  input  logic CLR,
  input  logic START,
  input  logic END,
  output logic Q
);
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) Q <= 1'b0;
    else Q <= CLR ? 1'b0 : START ? 1'b1 : END ? 1'b0 : Q;
endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: up/down counter with run flags, load, limit register, wrap/saturate and TC pulse.
// Define UPDOWN_COUNTER_CMP_EN to add the CMP_VAL / CMP_HIT compare output.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] LIMIT_RST = '1
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             CLR,
  input  logic             INC_START,
  input  logic             INC_END,
  input  logic             DEC_START,
  input  logic             DEC_END,
  input  logic             MODE_SEL,
  input  logic             HOLD,
  input  logic             LOAD,
  input  logic             LIM_WR,
  input  logic             WRAP_EN,
  input  logic [WIDTH-1:0] DIN,
`ifdef UPDOWN_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] CMP_VAL,
  output logic             CMP_HIT,
`endif
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY,
  output logic             TC
);
  localparam logic [WIDTH-1:0] ONE = 1;
  logic up_run, dn_run, boundary, stepping;
  logic [WIDTH-1:0] lim, step_val, dout_next;
  dir_e dir;
  counter_run_flag u_up (.CLK(CLK), .RESETn(RESETn), .CLR(CLR), .START(INC_START), .END(INC_END), .Q(up_run));
  counter_run_flag u_dn (.CLK(CLK), .RESETn(RESETn), .CLR(CLR), .START(DEC_START), .END(DEC_END), .Q(dn_run));
  assign dir = dir_e'(MODE_SEL);
  assign BUSY = (dir == DIR_UP) ? up_run : dn_run;
  always_comb begin
    boundary = (dir == DIR_UP) ? (DOUT >= lim) : (DOUT == '0);
    step_val = (dir == DIR_UP) ? (boundary ? (WRAP_EN ? '0 : lim) : DOUT + ONE)
                               : (boundary ? (WRAP_EN ? lim : '0) : DOUT - ONE);
    stepping = !CLR && BUSY && !HOLD;
    dout_next = CLR ? '0 : !BUSY ? (LOAD ? DIN : DOUT) : HOLD ? DOUT : step_val;
  end
  // the step above sees the old limit even when LIM_WR is active this cycle
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      DOUT <= '0;
      TC   <= 1'b0;
      lim  <= LIMIT_RST;
    end else begin
      DOUT <= dout_next;
      TC   <= stepping && boundary;
      if (LIM_WR) lim <= DIN;
    end
`ifdef UPDOWN_COUNTER_CMP_EN
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) CMP_HIT <= 1'b0;
    else CMP_HIT <= (dout_next == CMP_VAL);
`endif
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed scenarios plus randomized stimulus against a behavioural model.
module tb_updown_counter_n;
  logic CLK = 1'b0, RESETn = 1'b0;
  logic CLR = 0, INC_START = 0, INC_END = 0, DEC_START = 0, DEC_END = 0;
  logic MODE_SEL = 0, HOLD = 0, LOAD = 0, LIM_WR = 0, WRAP_EN = 0;
  logic [7:0] DIN = 0, DOUT;
  logic BUSY, TC;
`ifdef UPDOWN_COUNTER_CMP_EN
  logic [7:0] CMP_VAL = 8'h10;
  logic CMP_HIT;
`endif
  int checks = 0, failures = 0;
  int m_cnt, m_lim, m_up, m_dn, m_tc;

  updown_counter_n dut (
    .CLK(CLK), .RESETn(RESETn), .CLR(CLR), .INC_START(INC_START), .INC_END(INC_END),
    .DEC_START(DEC_START), .DEC_END(DEC_END), .MODE_SEL(MODE_SEL), .HOLD(HOLD),
    .LOAD(LOAD), .LIM_WR(LIM_WR), .WRAP_EN(WRAP_EN), .DIN(DIN),
`ifdef UPDOWN_COUNTER_CMP_EN
    .CMP_VAL(CMP_VAL), .CMP_HIT(CMP_HIT),
`endif
    .DOUT(DOUT), .BUSY(BUSY), .TC(TC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_lim = 255; m_up = 0; m_dn = 0; m_tc = 0;
  endtask

  // counter behaviour expressed directly in integer arithmetic
  task automatic model_update();
    int busy;
    busy = MODE_SEL ? m_up : m_dn;
    m_tc = 0;
    if (CLR) m_cnt = 0;
    else if (!busy) begin
      if (LOAD) m_cnt = DIN;
    end else if (!HOLD) begin
      if (MODE_SEL) begin
        if (m_cnt >= m_lim) begin m_cnt = WRAP_EN ? 0 : m_lim; m_tc = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = WRAP_EN ? m_lim : 0; m_tc = 1; end
        else m_cnt = m_cnt - 1;
      end
    end
    m_up = CLR ? 0 : INC_START ? 1 : INC_END ? 0 : m_up;
    m_dn = CLR ? 0 : DEC_START ? 1 : DEC_END ? 0 : m_dn;
    if (LIM_WR) m_lim = DIN;
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check("dout", DOUT, m_cnt);
    check("busy", BUSY, MODE_SEL ? m_up : m_dn);
    check("tc", TC, m_tc);
`ifdef UPDOWN_COUNTER_CMP_EN
    check("cmp_hit", CMP_HIT, m_cnt == CMP_VAL);
`endif
  endtask

  task automatic idle();
    {CLR, INC_START, INC_END, DEC_START, DEC_END, HOLD, LOAD, LIM_WR} = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_dout", DOUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_tc", TC, 0);
    RESETn = 1;
    // load FD, count up with wrap at limit FF
    LOAD = 1; DIN = 8'hFD; step();
    idle(); INC_START = 1; MODE_SEL = 1; WRAP_EN = 1; step();
    check("s1_idle", DOUT, 8'hFD);
    idle(); step(); check("s1_fe", DOUT, 8'hFE); check("s1_tc0", TC, 0);
    step(); check("s1_ff", DOUT, 8'hFF); check("s1_tc1", TC, 0);
    step(); check("s1_00", DOUT, 8'h00); check("s1_tc2", TC, 1);
    // limit 5, count from 3
    INC_END = 1; step();
    idle(); LIM_WR = 1; DIN = 8'h05; step();
    idle(); LOAD = 1; DIN = 8'h03; step();
    idle(); INC_START = 1; step();
    idle(); step(); check("s2_4", DOUT, 4);
    step(); check("s2_5", DOUT, 5);
    step(); check("s2_0", DOUT, 0); check("s2_tc", TC, 1);
    step(); check("s2_1", DOUT, 1);
    // down saturate from 1
    INC_END = 1; step();
    idle(); LOAD = 1; DIN = 8'h01; MODE_SEL = 0; WRAP_EN = 0; step();
    idle(); DEC_START = 1; step();
    idle(); step(); check("s3_0a", DOUT, 0); check("s3_tc0", TC, 0);
    step(); check("s3_0b", DOUT, 0); check("s3_tc1", TC, 1);
    // CLR beats INC_START while running at 40
    DEC_END = 1; step();
    idle(); LOAD = 1; DIN = 8'h40; MODE_SEL = 1; LIM_WR = 1; step();
    idle(); INC_START = 1; step();
    CLR = 1; step();
    check("s4_dout", DOUT, 0); check("s4_busy", BUSY, 0); check("s4_tc", TC, 0);
    // async reset while holding at 33, then limit back to FF
    idle(); LOAD = 1; DIN = 8'h33; LIM_WR = 1; DIN = 8'h33; step();
    idle(); INC_START = 1; step();
    idle(); HOLD = 1; WRAP_EN = 1; step();
    #2 RESETn = 0;
    #1 check("ar_dout", DOUT, 0); check("ar_busy", BUSY, 0); check("ar_tc", TC, 0);
    model_reset();
    @(negedge CLK); RESETn = 1;
    idle(); LOAD = 1; DIN = 8'hFE; step();
    idle(); INC_START = 1; step();
    idle(); step(); step(); check("ar_lim", DOUT, 0); check("ar_lim_tc", TC, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      CLR       = ($urandom % 25) == 0;
      INC_START = ($urandom % 4) == 0;
      INC_END   = ($urandom % 5) == 0;
      DEC_START = ($urandom % 4) == 0;
      DEC_END   = ($urandom % 5) == 0;
      if (($urandom % 8) == 0) MODE_SEL = ~MODE_SEL;
      HOLD      = ($urandom % 6) == 0;
      LOAD      = ($urandom % 3) == 0;
      LIM_WR    = ($urandom % 16) == 0;
      WRAP_EN   = ($urandom % 2) == 1;
      DIN       = (($urandom % 4) == 0) ? 8'($urandom % 8) : 8'($urandom);
`ifdef UPDOWN_COUNTER_CMP_EN
      if (($urandom % 64) == 0) CMP_VAL = 8'($urandom % 16);
`endif
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
